alu_exec_ctrl: RTL and testbench

- Upstream controller for the 8-bit combinational `alu` block; sits between an instruction source and the ALU.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from a small internal register file and drives registered `a`/`b`/`opcode` into `alu`.
- Writes the ALU result back to the register file and latches carry/zero into sticky flag registers.

---
 rtl/alu_exec_pkg.sv | 21 ++
 rtl/alu_exec_regfile.sv | 45 ++++
 rtl/alu_exec_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execution controller: data width, ALU opcodes, FSM states.
package alu_exec_pkg;

  localparam int DATA_W = 8;

  // Opcode encoding shared with the alu block.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_regfile.sv
// NUM_REGS x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port, synchronous reset to zero.
module alu_exec_regfile
  import alu_exec_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_addr == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wr_sel[i]) begin
        regs[i] <= wr_data;
      end
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller in front of the combinational alu block.
// Optional macro ALU_EXEC_FWD_EN: accept during EXEC with operand forwarding.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_ld,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [REG_AW-1:0] instr_rt,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t              state_reg, state_next;
  logic                fire;
  logic                ld_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic [DATA_W-1:0]   imm_reg;
  logic [DATA_W-1:0]   alu_a_reg, alu_b_reg;
  logic [2:0]          alu_opcode_reg;
  logic                flag_c_reg, flag_z_reg, done_reg;
  logic                wr_en;
  logic [DATA_W-1:0]   wb_data;
  logic [DATA_W-1:0]   rf_a, rf_b, opa, opb;

  assign wr_en   = (state_reg == ST_EXEC) && !rst;
  assign wb_data = ld_reg ? imm_reg : alu_result;

  alu_exec_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (rd_reg),
    .wr_data  (wb_data),
    .ra_addr  (instr_rs),
    .ra_data  (rf_a),
    .rb_addr  (instr_rt),
    .rb_data  (rf_b),
    .dbg_addr (rd_addr),
    .dbg_data (rd_data)
  );

`ifdef ALU_EXEC_FWD_EN
  // The in-flight result is written on the same edge the new operands are captured.
  assign opa = (state_reg == ST_EXEC && instr_rs == rd_reg) ? wb_data : rf_a;
  assign opb = (state_reg == ST_EXEC && instr_rt == rd_reg) ? wb_data : rf_b;
`else
  assign opa = rf_a;
  assign opb = rf_b;
`endif

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    case (state_reg)
      ST_IDLE: instr_ready = !rst;
      ST_EXEC: begin
`ifdef ALU_EXEC_FWD_EN
        instr_ready = !rst;
`else
        instr_ready = 1'b0;
`endif
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    fire = instr_valid && instr_ready;
    if (fire) begin
      state_next = ST_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      ld_reg         <= 1'b0;
      rd_reg         <= '0;
      imm_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      flag_c_reg     <= 1'b0;
      flag_z_reg     <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == ST_EXEC);
      if (fire) begin
        ld_reg  <= instr_ld;
        rd_reg  <= instr_rd;
        imm_reg <= instr_imm;
        // Loads leave the ALU operand registers untouched.
        if (!instr_ld) begin
          alu_a_reg      <= opa;
          alu_b_reg      <= opb;
          alu_opcode_reg <= instr_op;
        end
      end
      if (state_reg == ST_EXEC && !ld_reg) begin
        flag_c_reg <= alu_carry;
        flag_z_reg <= alu_zero;
      end
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_opcode = alu_opcode_reg;
  assign flag_c     = flag_c_reg;
  assign flag_z     = flag_z_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: sequential-ISA reference model plus a stand-in alu.
module tb_alu_exec_ctrl;

`ifdef ALU_EXEC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready, instr_ld;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs, instr_rt, rd_addr;
  logic [7:0] instr_imm, alu_a, alu_b, alu_result, rd_data;
  logic [2:0] alu_opcode;
  logic       alu_carry, alu_zero, flag_c, flag_z, done;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NUM_REGS(4), .REG_AW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ld(instr_ld),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .flag_c(flag_c), .flag_z(flag_z), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Stand-in alu: returns {carry, result}; sub carry is borrow.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b), 8'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, 8'(a << 1)};
      default: return {1'b0, a >> 1};
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_f(alu_opcode, alu_a, alu_b);
  assign alu_zero = (alu_result == 8'h00);

  // Reference model: architectural state plus the one instruction in flight.
  logic [7:0] m_regs [4];
  logic       m_fc, m_fz, exp_done;
  logic       pend_v, pend_ld;
  logic [2:0] pend_op;
  logic [1:0] pend_rd;
  logic [7:0] pend_a, pend_b, pend_imm;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_fc = 1'b0; m_fz = 1'b0; exp_done = 1'b0; pend_v = 1'b0; pend_ld = 1'b0;
    pend_op = 3'd0; pend_rd = 2'd0; pend_a = 8'h00; pend_b = 8'h00; pend_imm = 8'h00;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model at the edge.
  task automatic step(input logic r, input logic v, input logic ld, input logic [2:0] op,
                      input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                      input logic [7:0] imm);
    logic er, fire;
    logic [8:0] res;
    rst = r; instr_valid = v; instr_ld = ld; instr_op = op;
    instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    rd_addr = 2'($urandom);
    er = !r && (FWD || !pend_v);
    #1;
    chk("ready", instr_ready, er);
    chk("done", done, exp_done);
    chk("flag_c", flag_c, m_fc);
    chk("flag_z", flag_z, m_fz);
    chk("rd_data", rd_data, m_regs[rd_addr]);
    if (pend_v && !pend_ld) begin
      chk("alu_a", alu_a, pend_a);
      chk("alu_b", alu_b, pend_b);
      chk("alu_opcode", alu_opcode, pend_op);
    end
    if (done === 1'b1) done_seen++;
    last_ready = instr_ready;
    fire = v && er;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      exp_done = pend_v;
      if (pend_v) begin
        if (pend_ld) begin
          m_regs[pend_rd] = pend_imm;
        end else begin
          res = alu_f(pend_op, pend_a, pend_b);
          m_regs[pend_rd] = res[7:0];
          m_fc = res[8];
          m_fz = (res[7:0] == 8'h00);
        end
      end
      // Operands read after the previous write: plain in-order semantics.
      if (fire) begin
        pend_ld = ld; pend_op = op; pend_rd = rd; pend_imm = imm;
        pend_a = m_regs[rs]; pend_b = m_regs[rt];
      end
      pend_v = fire;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic do_ld(input logic [1:0] rd, input logic [7:0] imm);
    step(1'b0, 1'b1, 1'b1, 3'd0, rd, 2'd0, 2'd0, imm);
    idle();
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
    step(1'b0, 1'b1, 1'b0, op, rd, rs, rt, 8'h00);
    idle();
  endtask

  task automatic peek(input logic [1:0] addr, output logic [7:0] data);
    rd_addr = addr;
    #1;
    data = rd_data;
  endtask

  logic [7:0] pv;
  logic rdy0, rdy1, rdy2;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 3'd0;
    instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0; instr_imm = 8'h00; rd_addr = 2'd0;
    last_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
    rst = 1'b0;
    #1;
    chk("lit_reset_ready", instr_ready, 1'b1);
    chk("lit_reset_done", done, 1'b0);
    chk("lit_reset_alu_a", alu_a, 8'h00);

    // add: 0xF0 + 0x20 = 0x110
    do_ld(2'd0, 8'hF0);
    do_ld(2'd1, 8'h20);
    do_alu(3'd0, 2'd2, 2'd0, 2'd1);
    chk("lit_add_done", done, 1'b1);
    peek(2'd2, pv);
    chk("lit_add_r2", pv, 8'h10);
    chk("lit_add_c", flag_c, 1'b1);
    chk("lit_add_z", flag_z, 1'b0);

    do_alu(3'd1, 2'd3, 2'd1, 2'd1);
    peek(2'd3, pv);
    chk("lit_sub_r3", pv, 8'h00);
    chk("lit_sub_z", flag_z, 1'b1);
    chk("lit_sub_c", flag_c, 1'b0);

    do_ld(2'd0, 8'h10);
    do_alu(3'd1, 2'd2, 2'd0, 2'd1);
    peek(2'd2, pv);
    chk("lit_borrow_r2", pv, 8'hF0);
    chk("lit_borrow_c", flag_c, 1'b1);

    do_ld(2'd1, 8'h81);
    chk("lit_ld_keeps_c", flag_c, 1'b1);
    chk("lit_ld_keeps_z", flag_z, 1'b0);
    do_alu(3'd7, 2'd1, 2'd1, 2'd1);
    peek(2'd1, pv);
    chk("lit_shr_r1", pv, 8'h40);
    chk("lit_shr_c", flag_c, 1'b0);

    // valid held across EXEC: one acceptance unless forwarding allows issue in EXEC
    idle();
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 8'h00); rdy0 = last_ready;
    step(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 8'h00); rdy1 = last_ready;
    idle(); rdy2 = last_ready;
    idle(); idle(); idle();
    chk("lit_hold_ready0", rdy0, 1'b1);
    chk("lit_hold_ready1", rdy1, FWD);
    chk("lit_hold_ready2", rdy2, 1'b1);
    chk("lit_hold_done_count", done_seen, FWD ? 2 : 1);

    // reset while an add into r2 is in EXEC
    step(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
    do_ld(2'd0, 8'h05);
    idle();
    done_seen = 0;
    step(1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 2'd0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
    rst = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("lit_rst_exec_ready", instr_ready, 1'b1);
    chk("lit_rst_exec_done", done, 1'b0);
    peek(2'd2, pv);
    chk("lit_rst_exec_r2", pv, 8'h00);
    idle(); idle();
    chk("lit_rst_exec_no_done", done_seen, 0);

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
           3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
